// File: rtl/phy_lane_if.sv
// Lane-source and byte-stream bundle between the four lane sources, the
// transmit scheduler and the parallel-to-serial stage.
interface phy_lane_if;
    logic [7:0] In0;
    logic [7:0] In1;
    logic [7:0] In2;
    logic [7:0] In3;
    logic       valid0;
    logic       valid1;
    logic       valid2;
    logic       valid3;
    logic       ready_in;
    logic       pop0;
    logic       pop1;
    logic       pop2;
    logic       pop3;
    logic [7:0] data_out;
    logic       valid_out;
    logic       k_out;
    logic [1:0] lane_sel;
    logic       link_up;

    modport master (
        input  In0, In1, In2, In3,
        input  valid0, valid1, valid2, valid3,
        input  ready_in,
        output pop0, pop1, pop2, pop3,
        output data_out, valid_out, k_out, lane_sel, link_up
    );

    modport slave (
        output In0, In1, In2, In3,
        output valid0, valid1, valid2, valid3,
        output ready_in,
        input  pop0, pop1, pop2, pop3,
        input  data_out, valid_out, k_out, lane_sel, link_up
    );
endinterface

// File: rtl/phy_lane_scheduler.sv
// Round-robin transmit scheduler sharing the PHY byte path among four lanes,
// preceded by a fixed comma training sequence after reset.
//
// state    | meaning
// ST_TRAIN | sending COM symbols until TRAIN_CNT of them are accepted
// ST_IDLE  | link up, sending IDL, arbitrating among requesting lanes
// ST_SEND  | granted lane is popped for up to MAX_BURST bytes
module phy_lane_scheduler #(
    parameter logic [7:0]  COM_SYM   = 8'hBC,
    parameter logic [7:0]  IDL_SYM   = 8'h7C,
    parameter int unsigned TRAIN_CNT = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    phy_lane_if.master io_lane
);
    localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_CNT - 1);
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {ST_TRAIN, ST_IDLE, ST_SEND} state_t;

    state_t     r_state;
    logic [3:0] r_train_cnt;
    logic [3:0] r_burst_cnt;
    logic [1:0] r_rr_ptr;
    logic [1:0] r_grant;
    logic [7:0] r_data_out;
    logic       r_valid_out;
    logic       r_k_out;
    logic [1:0] r_lane_sel;
    logic       r_link_up;

    logic [3:0] w_valid;
    logic [7:0] w_lane_data [4];
    logic       w_grant_valid;
    logic       w_pop_any;
    logic [3:0] w_pop;
    logic [1:0] w_next_grant;

    assign w_valid        = {io_lane.valid3, io_lane.valid2, io_lane.valid1, io_lane.valid0};
    assign w_lane_data[0] = io_lane.In0;
    assign w_lane_data[1] = io_lane.In1;
    assign w_lane_data[2] = io_lane.In2;
    assign w_lane_data[3] = io_lane.In3;

    assign w_grant_valid = w_valid[r_grant];
    assign w_pop_any     = reset && (r_state == ST_SEND) && w_grant_valid && io_lane.ready_in;

    always_comb begin
        w_pop = 4'b0000;
        if (w_pop_any) begin
            w_pop[r_grant] = 1'b1;
        end
    end

    // Scan from lowest to highest priority so the lane nearest rr_ptr+1 wins.
    always_comb begin
        logic [1:0] v_idx;
        w_next_grant = r_rr_ptr;
        v_idx        = r_rr_ptr;
        for (int i = 4; i >= 1; i--) begin
            v_idx = r_rr_ptr + 2'(i);
            if (w_valid[v_idx]) begin
                w_next_grant = v_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_TRAIN;
            r_train_cnt <= 4'd0;
            r_burst_cnt <= 4'd0;
            r_rr_ptr    <= 2'd3;
            r_grant     <= 2'd0;
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
            r_k_out     <= 1'b0;
            r_lane_sel  <= 2'd0;
            r_link_up   <= 1'b0;
        end else begin
            case (r_state)
                ST_TRAIN: begin
                    r_data_out  <= COM_SYM;
                    r_k_out     <= 1'b1;
                    r_valid_out <= 1'b0;
                    if (io_lane.ready_in) begin
                        r_train_cnt <= r_train_cnt + 4'd1;
                        if (r_train_cnt == TRAIN_LAST) begin
                            r_state   <= ST_IDLE;
                            r_link_up <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    r_data_out  <= IDL_SYM;
                    r_k_out     <= 1'b1;
                    r_valid_out <= 1'b0;
                    if (|w_valid) begin
                        r_grant     <= w_next_grant;
                        r_burst_cnt <= 4'd0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_pop_any) begin
                        r_data_out  <= w_lane_data[r_grant];
                        r_valid_out <= 1'b1;
                        r_k_out     <= 1'b0;
                        r_lane_sel  <= r_grant;
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                        if (r_burst_cnt == BURST_LAST) begin
                            r_rr_ptr <= r_grant;
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_data_out  <= IDL_SYM;
                        r_k_out     <= 1'b1;
                        r_valid_out <= 1'b0;
                        // An emptied source gives up its grant; a plain stall keeps it.
                        if (!w_grant_valid) begin
                            r_rr_ptr <= r_grant;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_TRAIN;
            endcase
        end
    end

    assign io_lane.pop0      = w_pop[0];
    assign io_lane.pop1      = w_pop[1];
    assign io_lane.pop2      = w_pop[2];
    assign io_lane.pop3      = w_pop[3];
    assign io_lane.data_out  = r_data_out;
    assign io_lane.valid_out = r_valid_out;
    assign io_lane.k_out     = r_k_out;
    assign io_lane.lane_sel  = r_lane_sel;
    assign io_lane.link_up   = r_link_up;
endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Self-checking bench for phy_lane_scheduler: lane sources are modelled as
// byte queues and every popped byte is expected one edge later in order.
module tb_phy_lane_scheduler;
    logic clk = 1'b0;
    logic reset;
    logic tb_ready;

    always #5 clk = ~clk;

    phy_lane_if bus ();

    phy_lane_scheduler #(
        .COM_SYM   (8'hBC),
        .IDL_SYM   (8'h7C),
        .TRAIN_CNT (4),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .io_lane (bus)
    );

    logic [7:0] src_q [4][$];
    int         sb_q[$];
    int         pop_trace[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        bus.valid0 = (src_q[0].size() != 0);
        bus.valid1 = (src_q[1].size() != 0);
        bus.valid2 = (src_q[2].size() != 0);
        bus.valid3 = (src_q[3].size() != 0);
        bus.In0    = (src_q[0].size() != 0) ? src_q[0][0] : 8'h00;
        bus.In1    = (src_q[1].size() != 0) ? src_q[1][0] : 8'h00;
        bus.In2    = (src_q[2].size() != 0) ? src_q[2][0] : 8'h00;
        bus.In3    = (src_q[3].size() != 0) ? src_q[3][0] : 8'h00;
        bus.ready_in = tb_ready;
    endtask

    // One clock: drive at negedge, record pops, check registered outputs after the edge.
    task automatic step();
        logic [3:0] pops;
        logic       rst_now;
        int         plane;
        int         e;
        @(negedge clk);
        drive_src();
        #1;
        pops    = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
        rst_now = reset;
        plane   = 4;
        check_val("pop_onehot", 32'($countones(pops) <= 1), 1);
        if (!rst_now) check_val("pop_in_reset", pops, 0);
        for (int k = 0; k < 4; k++) begin
            if (pops[k]) begin
                plane = k;
                check_val("pop_src_nonempty", src_q[k].size() != 0, 1);
                if (src_q[k].size() != 0) begin
                    sb_q.push_back(k * 256 + int'(src_q[k][0]));
                    void'(src_q[k].pop_front());
                end
            end
        end
        pop_trace.push_back(plane);
        @(posedge clk);
        #1;
        if (!rst_now) begin
            check_val("rst_data", bus.data_out, 0);
            check_val("rst_valid", bus.valid_out, 0);
            check_val("rst_k", bus.k_out, 0);
            check_val("rst_lane_sel", bus.lane_sel, 0);
            check_val("rst_link_up", bus.link_up, 0);
        end else begin
            check_val("valid_latency", bus.valid_out, plane != 4);
            check_val("k_vs_valid", bus.k_out, !bus.valid_out);
            if (bus.valid_out && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_val("data_byte", bus.data_out, e % 256);
                check_val("lane_sel", bus.lane_sel, e / 256);
            end
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        tb_ready = 1'b1;
        step();
        step();
        sb_q.delete();
        pop_trace.delete();
        reset = 1'b1;
    endtask

    task automatic clear_src();
        for (int k = 0; k < 4; k++) src_q[k].delete();
    endtask

    initial begin
        int cnt;
        int lanes[$];
        int exp_burst[8] = '{1, 1, 1, 1, 3, 3, 1, 1};
        reset    = 1'b0;
        tb_ready = 1'b1;
        clear_src();
        drive_src();

        // Training with ready_in held high
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("train_com", bus.data_out, 8'hBC);
            check_val("train_k", bus.k_out, 1);
            if (i < 3) check_val("train_link_low", bus.link_up, 0);
        end
        step();
        check_val("train_idl", bus.data_out, 8'h7C);
        check_val("train_link_up", bus.link_up, 1);

        // Training with ready_in low every other cycle
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tb_ready = (i % 2 == 1);
            step();
            if (bus.data_out == 8'hBC) cnt++;
            else break;
        end
        tb_ready = 1'b1;
        check_val("train_slow_com_cycles", cnt, 8);
        check_val("train_slow_idl", bus.data_out, 8'h7C);
        check_val("train_slow_link_up", bus.link_up, 1);

        // Single lane 2, three bytes
        clear_src();
        src_q[2].push_back(8'h11);
        src_q[2].push_back(8'h22);
        src_q[2].push_back(8'h33);
        apply_reset();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 5; i++) check_val("single_no_early_pop", pop_trace[i], 4);
        check_val("single_pop_a", pop_trace[5], 2);
        check_val("single_pop_b", pop_trace[6], 2);
        check_val("single_pop_c", pop_trace[7], 2);
        check_val("single_pop_end", pop_trace[8], 4);
        check_val("single_src_drained", src_q[2].size(), 0);
        check_val("single_sb_drained", sb_q.size(), 0);

        // Round robin, all lanes full
        clear_src();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 20; i++) src_q[k].push_back(8'(k * 32 + i));
        apply_reset();
        for (int i = 0; i < 30; i++) step();
        for (int i = 0; i < 29; i++) begin
            int j;
            int exp_l;
            j     = i - 5;
            exp_l = (i < 5) ? 4 : ((j % 5 == 4) ? 4 : (j / 5) % 4);
            check_val($sformatf("rr_pop_%0d", i), pop_trace[i], exp_l);
        end

        // Burst limit with a short source
        clear_src();
        for (int i = 0; i < 6; i++) src_q[1].push_back(8'h40 + 8'(i));
        for (int i = 0; i < 2; i++) src_q[3].push_back(8'hA0 + 8'(i));
        apply_reset();
        for (int i = 0; i < 25; i++) step();
        lanes.delete();
        foreach (pop_trace[i]) if (pop_trace[i] != 4) lanes.push_back(pop_trace[i]);
        check_val("burst_pop_count", lanes.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < lanes.size()) check_val($sformatf("burst_order_%0d", i), lanes[i], exp_burst[i]);
        check_val("burst_one_idl_gap", pop_trace[9], 4);
        check_val("burst_lane3_after_gap", pop_trace[10], 3);

        // Stall mid-burst on lane 0
        clear_src();
        for (int i = 0; i < 8; i++) src_q[0].push_back(8'hC0 + 8'(i));
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (src_q[0].size() == 6) break;
        end
        check_val("stall_reached", src_q[0].size(), 6);
        tb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_no_pop", pop_trace[pop_trace.size() - 1], 4);
            check_val("stall_valid_low", bus.valid_out, 0);
            check_val("stall_idl", bus.data_out, 8'h7C);
        end
        tb_ready = 1'b1;
        step();
        check_val("stall_resume_lane", pop_trace[pop_trace.size() - 1], 0);
        for (int i = 0; i < 14; i++) step();
        check_val("stall_src_drained", src_q[0].size(), 0);
        check_val("stall_sb_drained", sb_q.size(), 0);

        // Reset during SEND
        clear_src();
        for (int i = 0; i < 10; i++) begin
            src_q[0].push_back(8'h50 + 8'(i));
            src_q[1].push_back(8'h60 + 8'(i));
        end
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (src_q[0].size() == 8) break;
        end
        check_val("rst_mid_reached", src_q[0].size(), 8);
        reset = 1'b0;
        step();
        check_val("rst_mid_link_down", bus.link_up, 0);
        check_val("rst_mid_pop_none", pop_trace[pop_trace.size() - 1], 4);
        sb_q.delete();
        pop_trace.delete();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 5; i++) check_val("rst_mid_retrain_no_pop", pop_trace[i], 4);
        check_val("rst_mid_lane0_first", pop_trace[5], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
